wb_arb2_bram: RTL
=================

Name: wb_arb2_bram

Overview:
- Two-master Wishbone arbiter that shares the single point-to-point BRAM slave (3-bit address, 32-bit data) between two bus masters.
- Round-robin, bus-cycle-granular: the grant is held for the whole of a master's CYC.
- Includes an ACK watchdog that terminates hung strobes with ERR.
- Sits between the masters and the BRAM slave in the interconnect top level.

Parameters:
AW, 3, address width (bits) of ADR on all ports
DW, 32, data width (bits) of all data buses
TIMEOUT, 16, cycles a granted STB may wait for ACK_I before ERR; legal range 2..255

Ports:
CLK_I  in  1  system clock, all state on rising edge
RST_N_I  in  1  reset, asynchronous assert, active-low
M0_CYC_I  in  1  master 0 bus-cycle request
M0_STB_I  in  1  master 0 strobe
M0_WE_I  in  1  master 0 write enable
M0_ADR_I  in  AW  master 0 address
M0_DAT_I  in  DW  master 0 write data
M0_ACK_O  out  1  master 0 acknowledge
M0_ERR_O  out  1  master 0 timeout error
M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I, M1_ACK_O, M1_ERR_O: same as M0_*, for master 1
M_DAT_O  out  DW  read data broadcast to both masters (= S_DAT_I)
S_CYC_O  out  1  slave cycle
S_STB_O  out  1  slave strobe
S_WE_O  out  1  slave write enable
S_ADR_O  out  AW  slave address
S_DAT_O  out  DW  slave write data
S_ACK_I  in  1  slave acknowledge
S_DAT_I  in  DW  slave read data
GNT_O  out  2  one-hot grant, for debug and the bench

Behaviour:
- Reset: RST_N_I low asynchronously clears all state.
  - GNT_O=00; state=IDLE; rr_last=1 (master 0 wins the first tie); wdog=0; ERR regs=0.
  - Consequently S_CYC_O/S_STB_O/S_WE_O=0, S_ADR_O/S_DAT_O=0, M*_ACK_O=0, M*_ERR_O=0.
  - Reset asserted mid-transfer aborts it immediately; no ACK/ERR is delivered afterwards.
- State machine, registered: IDLE, OWN0, OWN1. GNT_O is decoded from state.
  - IDLE: only M0_CYC_I -> OWN0. Only M1_CYC_I -> OWN1. Both -> the master != rr_last. Neither -> stay in IDLE.
  - OWNn: stay while Mn_CYC_I=1. On the edge where Mn_CYC_I=0, set rr_last=n and re-evaluate exactly as IDLE with the updated rr_last. Zero-cycle handover to a waiting master is required.
  - Arbitration latency: a master's CYC is seen by the slave no earlier than 1 cycle after CYC rises (grant registered).
- Datapath, combinational from the grant:
  - With GNT_O = one-hot(n): S_CYC_O=Mn_CYC_I; S_STB_O=Mn_STB_I & ~err_pend; S_WE_O, S_ADR_O, S_DAT_O = Mn_*.
  - With no grant: all slave outputs are 0.
  - Mn_ACK_O = S_ACK_I & GNT_O[n] & Mn_STB_I. The ungranted master never sees ACK.
  - M_DAT_O = S_DAT_I unconditionally.
- Watchdog (8-bit counter wdog):
  - Clears to 0 when S_STB_O=0, or S_ACK_I=1, or the grant changes.
  - Otherwise increments.
  - When wdog==TIMEOUT-1 with S_STB_O=1 and S_ACK_I=0: next cycle err_pend=1 and Mn_ERR_O=1 to the owner for exactly 1 cycle. S_STB_O is masked low that cycle; wdog=0.
  - ACK arriving in the same cycle as the terminal count takes precedence; no ERR is raised.
  - ERR does not release the grant; the master must still drop CYC.
- Simultaneous events:
  - Owner drops CYC while the other requests -> handover on that edge.
  - Both CYC rise in the same cycle from IDLE -> round-robin rule.
  - ACK_I with no grant is ignored.
- Master contract: a master holding STB without a grant simply stalls. No ordering is guaranteed between masters beyond the round-robin rule.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2;
  - READ/WRITE command constants (0/1) shared with the master bus-command tasks.
- One natural sub-module: wb_ack_wdog (counter, terminal compare, one-cycle ERR pulse), parameterised by TIMEOUT.
- The arbiter FSM and mux stay in the top.

Test Plan:
- M0 alone: write 0x0000_00A5 to adr 3, then read adr 3.
  - Response: GNT_O=01 one cycle after CYC; S_WE_O follows M0_WE_I; M0_ACK_O once per strobe; read M_DAT_O=0x0000_00A5; M1_ACK_O stays 0.
- Both CYC rise in the same cycle after reset, each doing 4 single cycles (release and re-request).
  - Response: grant order 0,1,0,1,0,1,0,1; each handover has 0 idle cycles between GNT_O changes.
- M0 holds CYC for 3 back-to-back strobes while M1 requests.
  - Response: GNT_O stays 01 through all 3 ACKs; switches to 10 on the edge M0_CYC_I falls.
- Slave ACK forced low, TIMEOUT=16, M1 owns and strobes.
  - Response: M1_ERR_O high for exactly 1 cycle, 16 cycles after S_STB_O first high; S_STB_O low that cycle; GNT_O still 10.
- ACK_I asserted exactly at wdog==15.
  - Response: ACK delivered; no ERR.
- RST_N_I pulsed low mid-strobe while M1 owns.
  - Response: GNT_O=00 and S_CYC_O=0 immediately (before next edge); after release with both requesting, M0 is granted first.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone BRAM arbiter.
// State encoding, bus command values and the round-robin pick rule.
package wb_arb_pkg;

  localparam int unsigned WDOG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Grant choice from a free bus: a lone requester wins, a tie goes to the master != rr_last.
  function automatic arb_state_e arb_pick(input logic i_c0, input logic i_c1,
                                          input logic i_rr_last);
    arb_state_e w_pick;
    w_pick = ST_IDLE;
    if (i_c0 && i_c1) w_pick = i_rr_last ? ST_OWN0 : ST_OWN1;
    else if (i_c0)    w_pick = ST_OWN0;
    else if (i_c1)    w_pick = ST_OWN1;
    return w_pick;
  endfunction

endpackage

// File: rtl/wb_ack_wdog.sv
// ACK watchdog: counts unanswered strobe cycles and raises a one-cycle error
// pending flag when the count reaches TIMEOUT-1 without an ACK.
module wb_ack_wdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_clr,
  output logic o_err_pend
);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_err_pend;
  logic              w_term;

  // ACK and a grant change both win over the terminal count.
  assign w_term = i_stb & ~i_ack & ~i_clr & (r_wdog == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog     <= '0;
      r_err_pend <= 1'b0;
    end else begin
      r_err_pend <= w_term;
      if (~i_stb | i_ack | i_clr | w_term) r_wdog <= '0;
      else                                 r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign o_err_pend = r_err_pend;

endmodule

// File: rtl/wb_arb2_bram.sv
// Round-robin, cycle-granular arbiter sharing one BRAM Wishbone slave between
// two masters, with an ACK watchdog that ends hung strobes with ERR.
module wb_arb2_bram
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = 3,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  input  logic          M0_CYC_I,
  input  logic          M0_STB_I,
  input  logic          M0_WE_I,
  input  logic [AW-1:0] M0_ADR_I,
  input  logic [DW-1:0] M0_DAT_I,
  output logic          M0_ACK_O,
  output logic          M0_ERR_O,
  input  logic          M1_CYC_I,
  input  logic          M1_STB_I,
  input  logic          M1_WE_I,
  input  logic [AW-1:0] M1_ADR_I,
  input  logic [DW-1:0] M1_DAT_I,
  output logic          M1_ACK_O,
  output logic          M1_ERR_O,
  output logic [DW-1:0] M_DAT_O,
  output logic          S_CYC_O,
  output logic          S_STB_O,
  output logic          S_WE_O,
  output logic [AW-1:0] S_ADR_O,
  output logic [DW-1:0] S_DAT_O,
  input  logic          S_ACK_I,
  input  logic [DW-1:0] S_DAT_I,
  output logic [1:0]    GNT_O
);

  arb_state_e r_state, w_state_nxt;
  logic       r_rr_last, w_rr_nxt;
  logic       w_err_pend;
  logic       w_gnt_chg;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state   <= ST_IDLE;
      r_rr_last <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  // Owner keeps the bus for its whole CYC; on release re-arbitrate in the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_last;
    case (r_state)
      ST_IDLE: w_state_nxt = arb_pick(M0_CYC_I, M1_CYC_I, r_rr_last);
      ST_OWN0: begin
        if (!M0_CYC_I) begin
          w_rr_nxt    = 1'b0;
          w_state_nxt = arb_pick(M0_CYC_I, M1_CYC_I, 1'b0);
        end
      end
      ST_OWN1: begin
        if (!M1_CYC_I) begin
          w_rr_nxt    = 1'b1;
          w_state_nxt = arb_pick(M0_CYC_I, M1_CYC_I, 1'b1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_gnt_chg = (w_state_nxt != r_state);

  always_comb begin
    GNT_O    = {r_state == ST_OWN1, r_state == ST_OWN0};
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    M_DAT_O  = S_DAT_I;
    if (GNT_O[0]) begin
      S_CYC_O = M0_CYC_I;
      S_STB_O = M0_STB_I & ~w_err_pend;
      S_WE_O  = M0_WE_I;
      S_ADR_O = M0_ADR_I;
      S_DAT_O = M0_DAT_I;
    end else if (GNT_O[1]) begin
      S_CYC_O = M1_CYC_I;
      S_STB_O = M1_STB_I & ~w_err_pend;
      S_WE_O  = M1_WE_I;
      S_ADR_O = M1_ADR_I;
      S_DAT_O = M1_DAT_I;
    end
    M0_ACK_O = S_ACK_I & GNT_O[0] & M0_STB_I;
    M1_ACK_O = S_ACK_I & GNT_O[1] & M1_STB_I;
    M0_ERR_O = w_err_pend & GNT_O[0];
    M1_ERR_O = w_err_pend & GNT_O[1];
  end

  wb_ack_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .i_clk     (CLK_I),
    .i_rst_n   (RST_N_I),
    .i_stb     (S_STB_O),
    .i_ack     (S_ACK_I),
    .i_clr     (w_gnt_chg),
    .o_err_pend(w_err_pend)
  );

endmodule
